// File: rtl/mult_sched_rr.sv
// Round-robin arbiter feeding one shift-add constant multiplier (x1/x3/x7/x8), one term per cycle.
// Handshake to out_valid is 2/3/4/2 cycles; a result is held in DONE until out_ready, with no new grants meanwhile.
module mult_sched_rr #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DW-1:0]   req_data,
   input  logic [NREQ*2-1:0]    req_sel,
   output logic [NREQ-1:0]      req_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW+2:0]        out_data,
   output logic [IDW-1:0]       out_id,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  id;
   logic [IDW-1:0]  win;
   logic            found;
   logic [DW-1:0]   d;
   logic [1:0]      sel;
   logic [1:0]      cnt;
   logic [1:0]      step;
   logic [DW+2:0]   acc;
   logic [DW+2:0]   term;
   logic [DW+2:0]   sum;

   function automatic logic [1:0] n_terms(input logic [1:0] s);
      case (s)
         2'b01:   return 2'd2;
         2'b10:   return 2'd3;
         default: return 2'd1;
      endcase
   endfunction

   // First valid requester at or after ptr, wrapping modulo NREQ.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int j = 0; j < NREQ; j++) begin
         idx = (int'(ptr) + j) % NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst && state == IDLE && found)
         req_ready[win] = 1'b1;
   end

   // Terms go out as d, d<<1, d<<2; x8 is the single term d<<3.
   assign step = n_terms(sel) - cnt;
   assign term = (sel == 2'b11) ? ({3'b000, d} << 3) : ({3'b000, d} << step);
   assign sum  = acc + term;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= '0;
         id        <= '0;
         d         <= '0;
         sel       <= '0;
         cnt       <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  d     <= req_data[win*DW +: DW];
                  sel   <= req_sel[win*2 +: 2];
                  cnt   <= n_terms(req_sel[win*2 +: 2]);
                  id    <= win;
                  acc   <= '0;
                  ptr   <= (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               acc <= sum;
               cnt <= cnt - 2'd1;
               if (cnt == 2'd1) begin
                  out_data  <= sum;
                  out_id    <= id;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_sched_rr.sv
// Directed bench for mult_sched_rr: grant order, latency, products, hold under backpressure, reset abort.
module tb_mult_sched_rr;
   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ*DW-1:0]  req_data = '0;
   logic [NREQ*2-1:0]   req_sel = '0;
   logic [NREQ-1:0]     req_ready;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [DW+2:0]       out_data;
   logic [IDW-1:0]      out_id;
   logic                busy;

   int n_chk = 0;
   int n_err = 0;

   mult_sched_rr #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_sel(req_sel), .req_ready(req_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated request from r, consumed immediately; optional change of its inputs after the handshake.
   task automatic single(input int r, input logic [7:0] dv, input logic [1:0] s, input bit mangle);
      int lat;
      int m;
      int el;
      case (s)
         2'b00:   begin m = 1; el = 2; end
         2'b01:   begin m = 3; el = 3; end
         2'b10:   begin m = 7; el = 4; end
         default: begin m = 8; el = 2; end
      endcase
      req_valid              = '0;
      req_valid[r]           = 1'b1;
      req_data[r*DW +: DW]   = dv;
      req_sel[r*2 +: 2]      = s;
      out_ready              = 1'b1;
      #1 check("single grant", req_ready, 32'(1) << r);
      tick();
      req_valid = '0;
      if (mangle) begin
         req_data[r*DW +: DW] = ~dv;
         req_sel[r*2 +: 2]    = s ^ 2'b11;
      end
      lat = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      check("single latency", lat, el);
      check("single product", out_data, int'(dv) * m);
      check("single id", out_id, r);
      tick();
      check("single back to idle", busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int g;
      int o;
      int lat;
      int w;
      int gseq [5] = '{0, 1, 2, 3, 0};
      logic [7:0] dtab [4] = '{8'd0, 8'd1, 8'd127, 8'd255};

      // Reset state, with a request pending that must not be granted.
      req_valid = 4'b0001;
      tick();
      tick();
      check("rst out_valid", out_valid, 0);
      check("rst busy", busy, 0);
      check("rst out_data", out_data, 0);
      check("rst out_id", out_id, 0);
      check("rst req_ready", req_ready, 0);

      // Requester 0, 0xFF x7.
      rst = 1'b1;
      req_data[0 +: DW] = 8'hFF;
      req_sel[0 +: 2]   = 2'b10;
      out_ready         = 1'b1;
      #1 check("x7 grant", req_ready, 4'b0001);
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 1) req_valid = '0;
         check("x7 busy", busy, (c <= 4) ? 1 : 0);
         check("x7 out_valid", out_valid, (c == 4) ? 1 : 0);
         if (c == 4) begin
            check("x7 out_data", out_data, 1785);
            check("x7 out_id", out_id, 0);
         end
      end

      // Four continuous x8 requesters from ptr=0.
      rst       = 1'b0;
      req_valid = 4'b1111;
      req_data  = {8'd40, 8'd30, 8'd20, 8'd10};
      req_sel   = 8'hFF;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      #1;
      g = 0;
      o = 0;
      for (int t = 0; t < 14; t++) begin
         if (req_ready != '0) begin
            check("rr grant", req_ready, 32'(1) << gseq[g % 5]);
            check("rr grant cycle", t, 3 * g);
            g++;
         end
         if (out_valid) begin
            check("rr out_id", out_id, o % 4);
            check("rr out_data", out_data, (o % 4 + 1) * 80);
            o++;
         end
         tick();
      end
      check("rr grant count", g, 5);
      check("rr result count", o, 4);
      req_valid = '0;
      w = 0;
      while (busy && w < 20) begin
         tick();
         w++;
      end
      check("rr drain", busy, 0);

      // Requester 2, 5 x3, held under backpressure while others request.
      req_valid          = 4'b0100;
      req_data[2*DW +: DW] = 8'd5;
      req_sel[2*2 +: 2]  = 2'b01;
      out_ready          = 1'b0;
      #1 check("bp grant", req_ready, 4'b0100);
      tick();
      req_valid = 4'b1011;
      lat = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      check("bp latency", lat, 3);
      for (int i = 0; i < 6; i++) begin
         check("bp out_valid", out_valid, 1);
         check("bp out_data", out_data, 15);
         check("bp out_id", out_id, 2);
         check("bp req_ready", req_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      #1 check("bp accept req_ready", req_ready, 0);
      check("bp accept busy", busy, 1);
      tick();
      check("bp idle", busy, 0);
      check("bp next winner", req_ready, 4'b1000);
      req_valid = '0;

      // Operand x scale sweep.
      for (int i = 0; i < 16; i++)
         single((i + i / 4) % 4, dtab[i / 4], 2'(i % 4), 1'b0);

      // Inputs changed right after the handshake must not matter.
      single(1, 8'd100, 2'b01, 1'b1);

      // Reset during a x7 calculation.
      single(2, 8'd3, 2'b00, 1'b0);
      req_valid            = 4'b0010;
      req_data[1*DW +: DW] = 8'd9;
      req_sel[1*2 +: 2]    = 2'b10;
      #1 check("abort grant", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      rst       = 1'b0;
      tick();
      rst = 1'b1;
      check("abort out_valid", out_valid, 0);
      check("abort busy", busy, 0);
      req_valid = 4'b1111;
      #1 check("abort ptr reset", req_ready, 4'b0001);
      req_valid = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("abort no result", out_valid, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/mult_sched_rr.md
# mult_sched_rr

Round-robin scheduler that shares one sequenced shift-add constant multiplier (×1, ×3, ×7, ×8) among NREQ requesters. Each requester presents an 8-bit operand and a 2-bit scale select over a valid/ready handshake. The block grants one requester at a time and builds the product one shifted term per cycle. It returns the result tagged with the requester id over a valid/ready output handshake. It sits between several producer blocks and the downstream consumer of scaled samples.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 8, operand width; result width is DW+3
- IDW, $clog2(NREQ), width of the requester id
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-low reset
- req_valid  input  NREQ  request valid, bit i for requester i
- req_data  input  NREQ*DW  operands, requester i at [i*DW +: DW]
- req_sel  input  NREQ*2  scale select, requester i at [i*2 +: 2]; 00=×1, 01=×3, 10=×7, 11=×8
- req_ready  output  NREQ  one-hot grant, combinational
- out_valid  output  1  result valid (registered)
- out_ready  input  1  consumer accepts result
- out_data  output  DW+3  product (registered)
- out_id  output  IDW  id of the requester that owns out_data (registered)
- busy  output  1  high in any state other than IDLE (registered)

## Operation
- Reset is synchronous, active-low, one clock, and takes precedence over everything.
- States: IDLE, CALC, DONE.
- IDLE:
  - The winner is the first i with req_valid[i]=1, scanning from ptr upward modulo NREQ.
  - req_ready is one-hot on the winner. It is all-zero when no req_valid is set or the state is not IDLE.
  - Handshake is req_valid[i] & req_ready[i]. On handshake:
    - Latch operand d, sel and id.
    - Clear acc.
    - Load the term counter with the number of terms.
    - Set ptr = (id+1) mod NREQ.
    - Go to CALC.
- Term schedule, one term per CALC cycle:
  - ×1: d (1 term)
  - ×3: d, d<<1 (2 terms)
  - ×7: d, d<<1, d<<2 (3 terms)
  - ×8: d<<3 (1 term)
- CALC: each cycle acc <= acc + current term and the counter decrements. On the last term, out_data <= final sum, out_id <= id, out_valid <= 1, and the state goes to DONE.
- DONE: out_valid, out_data and out_id are held stable until out_ready=1. On that edge out_valid <= 0 and the state goes to IDLE. out_data and out_id keep their last value.
- Arithmetic:
  - All sums are unsigned in DW+3 bits.
  - The maximum is 255×8 = 2040, so there is no overflow.
  - Zero-extend d before shifting.
- req_data and req_sel are sampled only on the handshake edge. Changes afterwards have no effect.
- A requester that drops req_valid while not granted is skipped with no penalty.
- ptr is not advanced when no handshake occurs.

## Timing
- Reset values: state=IDLE, ptr=0, out_valid=0, out_data=0, out_id=0, busy=0, acc=0. req_ready is 0 while rst=0.
- Handshake in cycle 0. CALC occupies cycles 1..k (k = 1, 2, 3, 1 for sel 00, 01, 10, 11). out_valid is first high in cycle k+1.
  - Latency from handshake to out_valid: 2 cycles for ×1 and ×8, 3 for ×3, 4 for ×7.
- If out_ready is already high in the first out_valid cycle, the result is consumed that cycle. The state is IDLE in the next cycle, so the next handshake can happen at the earliest in cycle k+2.
- There is no back-to-back acceptance. req_ready is 0 in CALC and DONE, including the out_ready handshake cycle.
- busy is 1 from cycle 1 through the out_ready handshake cycle inclusive.
- Reset asserted mid-CALC or in DONE discards the operation: out_valid is 0 next cycle and ptr returns to 0. The in-flight requester must re-request.
- Simultaneous requests: exactly one grant per IDLE cycle. Starvation-free: any continuously valid requester is granted within NREQ grants.

## Test plan
- Reset, then requester 0 presents d=8'hFF, sel=10 (×7), out_ready held at 1 -> req_ready=4'b0001 in cycle 0; busy 1..4; out_valid only in cycle 4 with out_data=11'd1785, out_id=0.
- All four valid continuously, sel=11, d=10,20,30,40, out_ready=1 -> grants in order 0,1,2,3,0. Results 80,160,240,320 with matching out_id. Each grant is 3 cycles after the previous one.
- Requester 2 granted with d=5, sel=01, out_ready held 0 for 6 cycles -> out_data=15 and out_id=2 stable, out_valid high throughout. req_ready=0 throughout even with other req_valid set. IDLE on the cycle after out_ready=1.
- Covered sweep: d in {0,1,127,255} × all sel -> out_data equals d×{1,3,7,8}. Latency is 2/3/4/2 cycles.
- Change req_data[requester 1] to a different value in the cycle after its handshake -> out_data reflects the originally sampled value.
- rst=0 for one cycle during CALC of a ×7 op -> next cycle out_valid=0 and busy=0. The next grant starts from requester 0.
